// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory: FSM state encoding, the default
// no-op instruction word and the boot image (address/word pairs).
package prog_mem_pkg;

  // FSM states: S_BOOT while the boot fill walks the whole array, S_RUN after.
  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Word returned for out-of-range fetches and written by the boot fill.
  localparam logic [15:0] NOP_INSN_DEFAULT = 16'h8000;

  // Boot image: every address not listed here is filled with the no-op word.
  localparam int BOOT_N = 7;
  localparam int BOOT_ADDR [BOOT_N] = '{6, 7, 8, 9, 10, 11, 12};
  localparam logic [15:0] BOOT_WORD [BOOT_N] = '{
    16'hd000, 16'h4080, 16'h2000, 16'h8000, 16'h0180, 16'h6120, 16'hc000
  };

endpackage

// File: rtl/prog_mem_ram.sv
// Instruction storage: DEPTH x W, one synchronous read port and one write
// port. A read and a write to the same address in one cycle return the new
// data (write-first). Read data holds while the read enable is low.
module prog_mem_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port with same-address bypass of the word being written.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Program memory with a fetch port (latency 1), a valid/ready loader port and
// an optional boot fill that writes a fixed image after reset.
// Optional feature macro: PROG_MEM_BOOT_PROG_EN enables the boot fill.
//
// Loader handshake: a word is accepted on a rising edge where
// load_valid && load_ready; load_ready is low only while the boot fill runs.
// The loader may change load_addr/load_data/load_last freely while not
// accepted. Fetches are single-cycle requests with no back-pressure; they are
// ignored (no insn_valid) while busy.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int                 INSN_W   = 16,
  parameter int                 PC_W     = 16,
  parameter int                 DEPTH    = 256,
  parameter logic [INSN_W-1:0]  NOP_INSN = INSN_W'(NOP_INSN_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn,
  output logic              fetch_oob,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [INSN_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so the range check also works when DEPTH == 2**PC_W.
  localparam logic [PC_W:0] DEPTH_X = (PC_W + 1)'(DEPTH);

`ifdef PROG_MEM_BOOT_PROG_EN
  localparam state_t RESET_STATE = S_BOOT;
`else
  localparam state_t RESET_STATE = S_RUN;
`endif

  state_t            state;
  logic [AW-1:0]     boot_cnt;
  logic              busy_q;
  logic [INSN_W-1:0] boot_wd;

  logic              fetch_in;
  logic              load_in;
  logic              fetch_fire;
  logic              load_fire;
  logic              sel_nop;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [INSN_W-1:0] ram_wdata;
  logic              ram_re;
  logic [INSN_W-1:0] ram_rdata;

  assign fetch_in   = ({1'b0, fetch_pc} < DEPTH_X);
  assign load_in    = ({1'b0, load_addr} < DEPTH_X);
  assign fetch_fire = fetch_req && !busy_q;
  assign load_fire  = load_valid && !busy_q;

  assign busy       = busy_q;
  assign load_ready = !busy_q;

  // Boot FSM: walk every address once, then stay in S_RUN until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      busy_q   <= (RESET_STATE == S_BOOT);
      boot_cnt <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          boot_cnt <= boot_cnt + AW'(1);
          if (boot_cnt == AW'(DEPTH - 1)) begin
            state  <= S_RUN;
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          state <= S_RUN;
        end
        default: begin
          state  <= S_RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Boot image lookup for the address currently being filled.
  always_comb begin
    boot_wd = NOP_INSN;
    for (int i = 0; i < BOOT_N; i++) begin
      if (BOOT_ADDR[i] == int'(boot_cnt)) begin
        boot_wd = INSN_W'(BOOT_WORD[i]);
      end
    end
  end

  // Write port source: boot fill owns the port while busy, loader otherwise.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_addr[AW-1:0];
    ram_wdata = load_data;
    if (busy_q) begin
      ram_we    = 1'b1;
      ram_waddr = boot_cnt;
      ram_wdata = boot_wd;
    end else if (load_fire && load_in) begin
      ram_we = 1'b1;
    end
  end

  assign ram_re = fetch_fire && fetch_in;

  prog_mem_ram #(
    .W     (INSN_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_pc[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Fetch result flags; insn and fetch_oob hold between accepted fetches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      insn_valid <= 1'b0;
      fetch_oob  <= 1'b0;
      sel_nop    <= 1'b1;
    end else begin
      insn_valid <= fetch_fire;
      if (fetch_fire) begin
        fetch_oob <= !fetch_in;
        sel_nop   <= !fetch_in;
      end
    end
  end

  // Out-of-range fetches and the reset value both present the no-op word.
  assign insn = sel_nop ? NOP_INSN : ram_rdata;

  // Loader status: done pulse after the last word, sticky range error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= load_fire && load_last;
      if (load_fire && !load_in) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Testbench for prog_mem. Builds with or without PROG_MEM_BOOT_PROG_EN; the
// boot-specific sequences are selected by the same macro.
module tb_prog_mem;

  localparam int          INSN_W = 16;
  localparam int          PC_W   = 16;
  localparam int          DEPTH  = 256;
  localparam int          AW     = 8;
  localparam logic [15:0] NOP    = 16'h8000;
`ifdef PROG_MEM_BOOT_PROG_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst_n;
  logic              fetch_req;
  logic [PC_W-1:0]   fetch_pc;
  logic              insn_valid;
  logic [INSN_W-1:0] insn;
  logic              fetch_oob;
  logic              load_valid;
  logic              load_ready;
  logic [PC_W-1:0]   load_addr;
  logic [INSN_W-1:0] load_data;
  logic              load_last;
  logic              load_done;
  logic              load_err;
  logic              busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prog_mem #(
    .INSN_W   (INSN_W),
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .NOP_INSN (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .insn_valid (insn_valid),
    .insn       (insn),
    .fetch_oob  (fetch_oob),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_done  (load_done),
    .load_err   (load_err),
    .busy       (busy)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory as an array plus "known" flags; boot fill modelled as loading the
  // whole image at reset and a countdown of busy cycles.
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          boot_left = 0;
  bit          m_valid = 1'b0;
  bit          m_oob = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          m_insn_known = 1'b0;
  logic [15:0] m_insn = 16'h0;
  bit          started = 1'b0;
  bit          busy_now;

  function automatic logic [15:0] boot_img(input int a);
    case (a)
      6:       return 16'hd000;
      7:       return 16'h4080;
      8:       return 16'h2000;
      9:       return 16'h8000;
      10:      return 16'h0180;
      11:      return 16'h6120;
      12:      return 16'hc000;
      default: return NOP;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started      = 1'b1;
      m_valid      = 1'b0;
      m_oob        = 1'b0;
      m_done       = 1'b0;
      m_err        = 1'b0;
      m_insn       = NOP;
      m_insn_known = 1'b1;
      if (BOOT_EN) begin
        boot_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[i]   = boot_img(i);
          m_known[i] = 1'b1;
        end
      end else begin
        boot_left = 0;
      end
    end else begin
      busy_now = (boot_left > 0);
      if (load_valid && !busy_now) begin
        if (int'(load_addr) < DEPTH) begin
          m_mem[load_addr[AW-1:0]]   = load_data;
          m_known[load_addr[AW-1:0]] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      m_done  = load_valid && !busy_now && load_last;
      m_valid = fetch_req && !busy_now;
      if (m_valid) begin
        if (int'(fetch_pc) >= DEPTH) begin
          m_insn       = NOP;
          m_insn_known = 1'b1;
          m_oob        = 1'b1;
        end else begin
          m_insn       = m_mem[fetch_pc[AW-1:0]];
          m_insn_known = m_known[fetch_pc[AW-1:0]];
          m_oob        = 1'b0;
        end
      end
      if (busy_now) boot_left--;
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (started) begin
      check_bit("busy", busy, boot_left > 0);
      check_bit("load_ready", load_ready, !(boot_left > 0));
      check_bit("insn_valid", insn_valid, m_valid);
      check_bit("load_done", load_done, m_done);
      check_bit("load_err", load_err, m_err);
      check_bit("fetch_oob", fetch_oob, m_oob);
      if (m_insn_known) check_word("insn", insn, m_insn);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check_bit("rst_insn_valid", insn_valid, 1'b0);
    check_word("rst_insn", insn, NOP);
    check_bit("rst_fetch_oob", fetch_oob, 1'b0);
    check_bit("rst_load_done", load_done, 1'b0);
    check_bit("rst_load_err", load_err, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic load_word(input int addr, input logic [15:0] data, input logic last);
    load_valid = 1'b1;
    load_addr  = PC_W'(addr);
    load_data  = data;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch_lit(input string name, input int pc, input logic [15:0] exp, input logic exp_oob);
    fetch_req = 1'b1;
    fetch_pc  = PC_W'(pc);
    step();
    fetch_req = 1'b0;
    @(negedge clk);
    check_bit({name, "_valid"}, insn_valid, 1'b1);
    check_word(name, insn, exp);
    check_bit({name, "_oob"}, fetch_oob, exp_oob);
    step();
  endtask

  // Counts cycles until busy drops, with a bound.
  task automatic wait_boot(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    check_int(name, n, BOOT_EN ? DEPTH : 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_pc   = '0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_last  = 1'b0;

    do_reset();

`ifdef PROG_MEM_BOOT_PROG_EN
    // Interrupt the boot at cycle 100 while trying to fetch and load.
    fetch_req  = 1'b1;
    fetch_pc   = 16'd6;
    load_valid = 1'b1;
    load_addr  = 16'd20;
    load_data  = 16'h5555;
    repeat (100) step();
    @(negedge clk);
    check_bit("boot_fetch_ignored", insn_valid, 1'b0);
    check_bit("boot_load_ready", load_ready, 1'b0);
    check_bit("boot_busy", busy, 1'b1);
    step();
    fetch_req  = 1'b0;
    load_valid = 1'b0;
    do_reset();
    wait_boot("boot_cycles");
    fetch_lit("boot_pc6", 6, 16'hd000, 1'b0);
    fetch_lit("boot_pc7", 7, 16'h4080, 1'b0);
    fetch_lit("boot_pc8", 8, 16'h2000, 1'b0);
    fetch_lit("boot_pc9", 9, 16'h8000, 1'b0);
    fetch_lit("boot_pc10", 10, 16'h0180, 1'b0);
    fetch_lit("boot_pc11", 11, 16'h6120, 1'b0);
    fetch_lit("boot_pc12", 12, 16'hc000, 1'b0);
    fetch_lit("boot_pc0", 0, 16'h8000, 1'b0);
    fetch_lit("boot_pc20", 20, 16'h8000, 1'b0);
`else
    @(negedge clk);
    check_bit("nb_load_ready", load_ready, 1'b1);
    check_bit("nb_busy", busy, 1'b0);
    step();
    wait_boot("boot_cycles");
`endif

    // Load with last, done pulse, then fetch back.
    load_word(3, 16'h1234, 1'b1);
    @(negedge clk);
    check_bit("done_pulse", load_done, 1'b1);
    step();
    @(negedge clk);
    check_bit("done_clear", load_done, 1'b0);
    step();
    fetch_lit("load_pc3", 3, 16'h1234, 1'b0);

    // Out of range: fetch and load at 300 (aliases 44 if truncated).
    load_word(44, 16'h4444, 1'b0);
    fetch_lit("oob_fetch", 300, 16'h8000, 1'b1);
    load_word(300, 16'h9999, 1'b1);
    @(negedge clk);
    check_bit("oob_err", load_err, 1'b1);
    check_bit("oob_done", load_done, 1'b1);
    step();
    repeat (3) step();
    check_bit("err_sticky", load_err, 1'b1);
    fetch_lit("oob_nochange", 44, 16'h4444, 1'b0);

    // Collision: same-cycle load and fetch to address 5.
    load_valid = 1'b1;
    load_addr  = 16'd5;
    load_data  = 16'hbeef;
    fetch_req  = 1'b1;
    fetch_pc   = 16'd5;
    step();
    load_valid = 1'b0;
    fetch_req  = 1'b0;
    @(negedge clk);
    check_word("collision", insn, 16'hbeef);
    step();

    // Back-to-back loads, one per cycle, then read them back.
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_addr  = PC_W'(100 + i);
      load_data  = 16'ha500 + 16'(i);
      load_last  = (i == 15);
      @(negedge clk);
      check_bit("b2b_ready", load_ready, 1'b1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int i = 0; i < 16; i += 5) begin
      fetch_lit("b2b_read", 100 + i, 16'ha500 + 16'(i), 1'b0);
    end

    // Randomized traffic checked by the model.
    for (int c = 0; c < 400; c++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      load_addr  = PC_W'($urandom_range(0, DEPTH + 40));
      load_data  = 16'($urandom);
      load_last  = ($urandom_range(0, 3) == 0);
      fetch_req  = ($urandom_range(0, 2) != 0);
      fetch_pc   = ($urandom_range(0, 3) == 0) ? load_addr : PC_W'($urandom_range(0, DEPTH + 40));
      step();
    end
    load_valid = 1'b0;
    fetch_req  = 1'b0;
    load_last  = 1'b0;

    // Reset clears flags; storage survives unless refilled by boot.
    do_reset();
    @(negedge clk);
    check_bit("post_reset_err", load_err, 1'b0);
    step();
    wait_boot("boot_cycles_2");
    for (int c = 0; c < 60; c++) begin
      fetch_req = 1'b1;
      fetch_pc  = PC_W'($urandom_range(0, DEPTH + 20));
      step();
    end
    fetch_req = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
